// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
// Shared constants for the multi-port register file:
//   - FSM state encoding (ST_INIT clear phase, ST_RUN normal operation)
//   - default geometry (DEF_DATA_W, DEF_ADDR_W, DEF_NUM_RD)
//   - ZERO_WORD, the value the clear engine writes
//   - EN / DIS enable literals
//   - RST_ACTIVE, the reset level of this block (active-low)
// No ports.
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

    localparam logic EN  = 1'b1;
    localparam logic DIS = 1'b0;

    localparam logic RST_ACTIVE = 1'b0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bus between decode/writeback (master) and the register file (slave).
//   ready       slave->master  clear sequence finished
//   we/waddr/wdata              two write ports, port p at [p*W +: W]
//   re/raddr                    NUM_RD read requests, packed per port
//   rdata/rbusy slave->master  read data and scoreboard busy flag per port
//   claim_en/claim_addr         mark a register as pending write
// -----------------------------------------------------------------------------
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
);

    logic                       ready;
    logic [1:0]                 we;
    logic [2*ADDR_W-1:0]        waddr;
    logic [2*DATA_W-1:0]        wdata;
    logic [NUM_RD-1:0]          re;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic [NUM_RD-1:0]          rbusy;
    logic                       claim_en;
    logic [ADDR_W-1:0]          claim_addr;

    modport master (
        input  ready, rdata, rbusy,
        output we, waddr, wdata, re, raddr, claim_en, claim_addr
    );

    modport slave (
        output ready, rdata, rbusy,
        input  we, waddr, wdata, re, raddr, claim_en, claim_addr
    );

endinterface

// File: rtl/regfile_mp_rdport.sv
// -----------------------------------------------------------------------------
// regfile_rdport
// One combinational read port: zero gating, write forwarding and busy flag.
//   ready     in   register file is out of its clear phase
//   re        in   read enable
//   raddr     in   read address
//   wr_en     in   effective write enables (already gated by RUN and addr != 0)
//   waddr0/1  in   write addresses of port 0 / port 1
//   wdata0/1  in   write data of port 0 / port 1
//   reg_data  in   stored value at raddr
//   busy_bit  in   scoreboard bit at raddr (0 when the scoreboard is absent)
//   rdata     out  read result
//   rbusy     out  RAW hazard flag for this port
// -----------------------------------------------------------------------------
module regfile_rdport
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              ready,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [1:0]        wr_en,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              busy_bit,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);

    logic hit0;
    logic hit1;

    // Port 1 is checked first so it wins when both ports target raddr.
    // A forwarded value is current, so the busy flag is suppressed on a hit.
    always_comb begin
        hit0  = wr_en[0] && (waddr0 == raddr);
        hit1  = wr_en[1] && (waddr1 == raddr);
        rdata = DATA_W'(ZERO_WORD);
        rbusy = DIS;
        if (ready && re && (raddr != '0)) begin
            if (hit1) begin
                rdata = wdata1;
            end else if (hit0) begin
                rdata = wdata0;
            end else begin
                rdata = reg_data;
            end
            rbusy = busy_bit && !(hit0 || hit1);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port register file: two write ports, NUM_RD combinational read ports
// with write forwarding, a sequential clear engine run after every reset and
// an optional per-register busy scoreboard.
//   clk   in  clock, rising edge
//   rst   in  asynchronous reset, active-low
//   bus   regfile_mp_if.slave (ready, writes, reads, claims)
// Optional feature: define REGFILE_SCOREBOARD_EN to build the busy scoreboard;
// without it claims are ignored and rbusy is always 0.
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                ready;
    logic [DATA_W-1:0]   regs [DEPTH];

    logic [ADDR_W-1:0]   waddr0;
    logic [ADDR_W-1:0]   waddr1;
    logic [DATA_W-1:0]   wdata0;
    logic [DATA_W-1:0]   wdata1;
    logic                wr0;
    logic                wr1;
    logic [NUM_RD*DATA_W-1:0] rdata_w;
    logic [NUM_RD-1:0]   rbusy_w;

    assign waddr0 = bus.waddr[0      +: ADDR_W];
    assign waddr1 = bus.waddr[ADDR_W +: ADDR_W];
    assign wdata0 = bus.wdata[0      +: DATA_W];
    assign wdata1 = bus.wdata[DATA_W +: DATA_W];

    // Writes only take effect in RUN and never to the hard-wired zero register.
    assign wr0 = ready && bus.we[0] && (waddr0 != '0);
    assign wr1 = ready && bus.we[1] && (waddr1 != '0);

    // State register plus clear counter; the counter only advances in INIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Leave INIT once the last register has been cleared.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (clr_cnt == LAST_ADDR) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        ready = (state == ST_RUN);
    end

    // Storage has no reset; the clear engine zeroes it, and in RUN port 1 is
    // written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            regs[clr_cnt] <= DATA_W'(ZERO_WORD);
        end else begin
            if (wr0) regs[waddr0] <= wdata0;
            if (wr1) regs[waddr1] <= wdata1;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] busy;

    // Writes retire a pending register; a claim in the same cycle comes from a
    // younger instruction, so it is applied last and the bit stays set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else if (ready) begin
            if (wr0) busy[waddr0] <= DIS;
            if (wr1) busy[waddr1] <= DIS;
            if (bus.claim_en && (bus.claim_addr != '0)) begin
                busy[bus.claim_addr] <= EN;
            end
        end
    end
`else
    logic unused_claim;
    assign unused_claim = ^{bus.claim_en, bus.claim_addr};
`endif

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              busy_bit;

        assign ra = bus.raddr[r*ADDR_W +: ADDR_W];
`ifdef REGFILE_SCOREBOARD_EN
        assign busy_bit = busy[ra];
`else
        assign busy_bit = DIS;
`endif

        regfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rdport (
            .ready    (ready),
            .re       (bus.re[r]),
            .raddr    (ra),
            .wr_en    ({wr1, wr0}),
            .waddr0   (waddr0),
            .waddr1   (waddr1),
            .wdata0   (wdata0),
            .wdata1   (wdata1),
            .reg_data (regs[ra]),
            .busy_bit (busy_bit),
            .rdata    (rdata_w[r*DATA_W +: DATA_W]),
            .rbusy    (rbusy_w[r])
        );
    end

    assign bus.rdata = rdata_w;
    assign bus.rbusy = rbusy_w;
    assign bus.ready = ready;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp (DATA_W=32, ADDR_W=5, NUM_RD=2). Expected
// responses are queued as stimulus is applied and checked by an independent
// monitor on the falling edge. Busy expectations follow REGFILE_SCOREBOARD_EN.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

`ifdef REGFILE_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    typedef struct {
        logic          rst;
        logic [1:0]    we;
        logic [AW-1:0] wa0;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd0;
        logic [DW-1:0] wd1;
        logic [1:0]    re;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic          ce;
        logic [AW-1:0] ca;
    } stim_t;

    typedef struct {
        string         name;
        logic          ready;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    busy;
    } exp_t;

    logic  clk;
    logic  rst;
    stim_t s;
    exp_t  q[$];
    int    vectors;
    int    miscompares;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic setStim(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                           input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                           input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                           input logic ce, input logic [AW-1:0] ca);
        s.we = we;  s.wa0 = wa0; s.wd0 = wd0; s.wa1 = wa1; s.wd1 = wd1;
        s.re = re;  s.ra0 = ra0; s.ra1 = ra1; s.ce = ce;   s.ca = ca;
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue the
    // response expected while those inputs are held.
    task automatic applyStimulus(input string name, input logic eReady,
                                 input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                 input logic [1:0] eBusy);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = s.rst;
        bus.we         = s.we;
        bus.waddr      = {s.wa1, s.wa0};
        bus.wdata      = {s.wd1, s.wd0};
        bus.re         = s.re;
        bus.raddr      = {s.ra1, s.ra0};
        bus.claim_en   = s.ce;
        bus.claim_addr = s.ca;
        e.name  = name;
        e.ready = eReady;
        e.d0    = e0;
        e.d1    = e1;
        e.busy  = eBusy;
        q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (bus.ready !== e.ready || bus.rdata !== {e.d1, e.d0} || bus.rbusy !== e.busy) begin
            miscompares++;
            $display("[TB] FAIL %s: got ready=%b rdata=%h rbusy=%b, expected ready=%b rdata=%h rbusy=%b",
                     e.name, bus.ready, bus.rdata, bus.rbusy, e.ready, {e.d1, e.d0}, e.busy);
        end
    endtask

    // Monitor: compare outputs mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            checkOutput(q.pop_front());
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        s.rst = 1'b0;
        setStim(2'b11, 5'd5, 32'hDEAD_0005, 5'd5, 32'hBEEF_0005, 2'b11, 5'd1, 5'd5, 1'b1, 5'd5);
        rst            = 1'b0;
        bus.we         = '0;
        bus.waddr      = '0;
        bus.wdata      = '0;
        bus.re         = '0;
        bus.raddr      = '0;
        bus.claim_en   = 1'b0;
        bus.claim_addr = '0;

        // Held in reset: everything zero.
        applyStimulus("reset_hold_0", 1'b0, 32'h0, 32'h0, 2'b00);
        applyStimulus("reset_hold_1", 1'b0, 32'h0, 32'h0, 2'b00);

        // Release reset while writing and claiming r5; clear phase is DEPTH cycles.
        s.rst = 1'b1;
        applyStimulus("init_release", 1'b0, 32'h0, 32'h0, 2'b00);
        for (int i = 1; i < DEPTH; i++) begin
            s.ra0 = AW'(i);
            applyStimulus($sformatf("init_lockout_%0d", i), 1'b0, 32'h0, 32'h0, 2'b00);
        end

        // First RUN cycle: r5 was neither written nor claimed during INIT.
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd1, 1'b0, 5'd0);
        applyStimulus("run_ready_r5", 1'b1, 32'h0, 32'h0, 2'b00);
        for (int i = 0; i < 16; i++) begin
            s.ra0 = AW'(2*i + 1);
            s.ra1 = AW'(2*i + 2);
            applyStimulus($sformatf("cleared_pair_%0d", i), 1'b1, 32'h0, 32'h0, 2'b00);
        end

        // Dual write to r3, port 1 wins, forwarded the same cycle.
        setStim(2'b11, 5'd3, 32'h1111, 5'd3, 32'h2222, 2'b11, 5'd3, 5'd4, 1'b0, 5'd0);
        applyStimulus("dual_wr_fwd", 1'b1, 32'h2222, 32'h0, 2'b00);
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd4, 1'b0, 5'd0);
        applyStimulus("dual_wr_stored", 1'b1, 32'h2222, 32'h0, 2'b00);

        // Port 0 write forwarded to read port 1; read port 0 disabled.
        setStim(2'b01, 5'd4, 32'h4444, 5'd0, 32'h0, 2'b10, 5'd3, 5'd4, 1'b0, 5'd0);
        applyStimulus("p0_wr_fwd_re_off", 1'b1, 32'h0, 32'h4444, 2'b00);
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd4, 1'b0, 5'd0);
        applyStimulus("p0_wr_stored", 1'b1, 32'h4444, 32'h4444, 2'b00);

        // r0 is hard-wired: writes and claims have no effect.
        setStim(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0);
        applyStimulus("r0_wr_claim", 1'b1, 32'h0, 32'h0, 2'b00);
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0);
        applyStimulus("r0_after", 1'b1, 32'h0, 32'h0, 2'b00);

        // Claim r7: busy appears the following cycle, gated by re.
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd7, 1'b1, 5'd7);
        applyStimulus("claim_r7_same", 1'b1, 32'h0, 32'h0, 2'b00);
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd7, 1'b0, 5'd0);
        applyStimulus("claim_r7_next_p0", 1'b1, 32'h0, 32'h0, {1'b0, SB});
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd7, 1'b0, 5'd0);
        applyStimulus("claim_r7_both", 1'b1, 32'h0, 32'h0, {SB, SB});

        // Writing r7 forwards data and masks busy, then retires the claim.
        setStim(2'b01, 5'd7, 32'hABCD, 5'd0, 32'h0, 2'b11, 5'd7, 5'd7, 1'b0, 5'd0);
        applyStimulus("wr_r7_fwd", 1'b1, 32'hABCD, 32'hABCD, 2'b00);
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd7, 1'b0, 5'd0);
        applyStimulus("wr_r7_retired", 1'b1, 32'hABCD, 32'hABCD, 2'b00);

        // Claim and write r7 together: claim wins, busy next cycle.
        setStim(2'b10, 5'd0, 32'h0, 5'd7, 32'h1234, 2'b11, 5'd7, 5'd7, 1'b1, 5'd7);
        applyStimulus("claim_wr_r7", 1'b1, 32'h1234, 32'h1234, 2'b00);
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd7, 1'b0, 5'd0);
        applyStimulus("claim_wr_r7_next", 1'b1, 32'h1234, 32'h1234, {SB, SB});

        // Make r9 = 0x55 and busy.
        setStim(2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 2'b11, 5'd9, 5'd7, 1'b0, 5'd0);
        applyStimulus("wr_r9", 1'b1, 32'h55, 32'h1234, {SB, 1'b0});
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd7, 1'b1, 5'd9);
        applyStimulus("claim_r9", 1'b1, 32'h55, 32'h1234, {SB, 1'b0});
        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd7, 1'b0, 5'd0);
        applyStimulus("r9_busy", 1'b1, 32'h55, 32'h1234, {SB, SB});

        // Asynchronous reset mid-RUN: ready drops before the next rising edge.
        s.rst = 1'b0;
        applyStimulus("mid_reset_async", 1'b0, 32'h0, 32'h0, 2'b00);
        applyStimulus("mid_reset_hold", 1'b0, 32'h0, 32'h0, 2'b00);
        s.rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus($sformatf("re_init_%0d", i), 1'b0, 32'h0, 32'h0, 2'b00);
        end
        applyStimulus("re_run_r9_cleared", 1'b1, 32'h0, 32'h0, 2'b00);

        setStim(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        applyStimulus("idle_end", 1'b1, 32'h0, 32'h0, 2'b00);
        repeat (3) @(posedge clk);

        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL queue_drain: got %0d pending, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
